// File: rtl/sqrt_share_pkg.sv
// Shared types and sizing helpers for the square-root sharing arbiter.
package sqrt_share_pkg;

    // Controller states: waiting for a request, holding the radicand, offering the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH   = 4;
    // The extractor needs 4*WIDTH cycles to settle; this is the smallest safe hold time.
    localparam int DEFAULT_LATENCY = 4 * DEFAULT_WIDTH;

    // Bits needed to index n items; never less than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sqrt_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above the pointer, wrapping around. The pointer register lives in the parent.
module rr_arbiter
    import sqrt_share_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic           found;

    // Scan NREQ candidates starting at the pointer; the first valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDW + 1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[IDW-1:0];
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Shares one square_extractor among NREQ requesters. One request is accepted
// at a time (round-robin), its radicand is held on ext_radicand for LATENCY
// cycles, then root and remainder are returned tagged with the requester ID.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Requesters hold req_valid and their radicand until accepted; the
// response holds rsp_* stable while rsp_valid=1 and rsp_ready=0.
module sqrt_share_arbiter
    import sqrt_share_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NREQ    = 4,
    parameter int LATENCY = DEFAULT_LATENCY,
    localparam int IDW    = id_width(NREQ),
    localparam int RW     = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*RW-1:0]   req_radicand,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [WIDTH-1:0]     rsp_root,
    output logic [WIDTH:0]       rsp_rem,
    output logic [RW-1:0]        ext_radicand,
    input  logic [WIDTH-1:0]     ext_dout,
    input  logic [WIDTH:0]       ext_remainder,
    output logic [1:0]           fsm_state
);

    localparam int CW                 = id_width(LATENCY);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [CW-1:0]   cnt;
    logic            arb_en;
    logic            accept;
    logic            sample;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [RW-1:0]   rad_arr [NREQ];

    // Grants are only offered in IDLE and never while reset is asserted.
    assign arb_en    = rst_n && (state == IDLE);
    assign req_ready = grant;
    assign fsm_state = state;
    assign ptr_next  = (grant_idx == ID_LAST) ? '0 : grant_idx + IDW'(1);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Unpack the flat radicand bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rad_arr[i] = req_radicand[i*RW +: RW];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the accept/sample strobes that steer the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture the granted radicand, count the hold time, latch results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            cnt          <= '0;
            ext_radicand <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_root     <= '0;
            rsp_rem      <= '0;
        end else begin
            if (accept) begin
                ext_radicand <= rad_arr[grant_idx];
                rsp_id       <= grant_idx;
                ptr          <= ptr_next;
                cnt          <= '0;
            end
            if (state == RUN) begin
                cnt <= cnt + CW'(1);
            end
            if (sample) begin
                rsp_root  <= ext_dout;
                rsp_rem   <= ext_remainder;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Directed bench for sqrt_share_arbiter with a behavioural square extractor
// on the ext_* ports (WIDTH=4, NREQ=4, LATENCY=16).
module tb_sqrt_share_arbiter;

    localparam int WIDTH   = 4;
    localparam int NREQ    = 4;
    localparam int LATENCY = 16;
    localparam int IDW     = 2;
    localparam int RW      = 8;
    localparam int EW      = IDW + WIDTH + WIDTH + 1;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*RW-1:0]  req_radicand;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [WIDTH-1:0]    rsp_root;
    logic [WIDTH:0]      rsp_rem;
    logic [RW-1:0]       ext_radicand;
    logic [WIDTH-1:0]    ext_dout;
    logic [WIDTH:0]      ext_remainder;
    logic [1:0]          fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    sqrt_share_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .LATENCY (LATENCY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_radicand  (req_radicand),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_root      (rsp_root),
        .rsp_rem       (rsp_rem),
        .ext_radicand  (ext_radicand),
        .ext_dout      (ext_dout),
        .ext_remainder (ext_remainder),
        .fsm_state     (fsm_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Extractor model: 12-cycle delay line followed by an exact integer sqrt.
    logic [RW-1:0] pipe [12];
    always @(posedge clk) begin
        pipe[0] <= ext_radicand;
        for (int k = 1; k < 12; k++) pipe[k] <= pipe[k-1];
    end

    always_comb begin
        int xi;
        int ri;
        xi = int'(pipe[11]);
        ri = 0;
        for (int k = 0; k < 16; k++) if (k * k <= xi) ri = k;
        ext_dout      = WIDTH'(ri);
        ext_remainder = (WIDTH + 1)'(xi - ri * ri);
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] rad);
        req_valid[i]            = 1'b1;
        req_radicand[i*RW +: RW] = rad;
    endtask

    task automatic push_exp(input int id, input int root, input int rem);
        exp_q.push_back({IDW'(id), WIDTH'(root), (WIDTH + 1)'(rem)});
    endtask

    // Wait for the next grant, check it against the queue head, then collect the response.
    task automatic serve_one(input string tag, output int waited);
        logic [EW-1:0] e;
        int id;
        int lat;
        rsp_ready = 1'b1;
        waited    = 0;
        while (req_ready == '0 && waited < 60) begin
            tick();
            waited++;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e  = exp_q.pop_front();
            id = int'(e[EW-1 -: IDW]);
            check({tag, "_grant"}, 32'(req_ready), 32'(1) << id);
            tick();
            req_valid[id] = 1'b0;
            check({tag, "_ready_run"}, 32'(req_ready), 32'd0);
            lat = 0;
            while (!rsp_valid && lat < 40) begin
                tick();
                lat++;
            end
            check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
            check({tag, "_id"},   32'(rsp_id),   32'(e[EW-1 -: IDW]));
            check({tag, "_root"}, 32'(rsp_root), 32'(e[2*WIDTH -: WIDTH]));
            check({tag, "_rem"},  32'(rsp_rem),  32'(e[WIDTH:0]));
            tick();
            check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    // Directed sequence.
    initial begin
        int w;
        int lat;
        bit seen;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_radicand = '0;
        rsp_ready    = 1'b0;

        // Reset values, with every request line asserted to show ready is gated.
        req_valid = 4'hF;
        #3;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        check("rst_root",  32'(rsp_root),  32'd0);
        check("rst_rem",   32'(rsp_rem),   32'd0);
        check("rst_ext",   32'(ext_radicand), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        do_reset();

        // 1: single request from requester 2, radicand 200.
        set_req(2, 8'd200);
        push_exp(2, 14, 4);
        #1;
        check("s1_ready_pre", 32'(req_ready), 32'b0100);
        serve_one("s1", w);

        // 2: all four valid after reset; served 0,1,2,3.
        do_reset();
        set_req(0, 8'd0);
        set_req(1, 8'd1);
        set_req(2, 8'd255);
        set_req(3, 8'd144);
        push_exp(0, 0, 0);
        push_exp(1, 1, 0);
        push_exp(2, 15, 30);
        push_exp(3, 12, 0);
        #1;
        for (int k = 0; k < 4; k++) serve_one("s2", w);

        // 3: serve 1, then 0 and 3 together; 3 wins, pointer wraps to 0.
        set_req(1, 8'd50);
        push_exp(1, 7, 1);
        #1;
        serve_one("s3a", w);
        set_req(0, 8'd16);
        set_req(3, 8'd99);
        push_exp(3, 9, 18);
        push_exp(0, 4, 0);
        #1;
        serve_one("s3b", w);
        serve_one("s3c", w);

        // 4: response backpressure with requester 0 waiting.
        rsp_ready = 1'b0;
        set_req(2, 8'd120);
        #1;
        check("s4_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        set_req(0, 8'd36);
        #1;
        check("s4_ready_run", 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("s4_latency", 32'(lat), 32'(LATENCY));
        for (int k = 0; k < 10; k++) begin
            tick();
            check("s4_hold_valid", 32'(rsp_valid), 32'd1);
            check("s4_hold_id",    32'(rsp_id),    32'd2);
            check("s4_hold_root",  32'(rsp_root),  32'd10);
            check("s4_hold_rem",   32'(rsp_rem),   32'd20);
            check("s4_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("s4_rsp_drop", 32'(rsp_valid), 32'd0);
        push_exp(0, 6, 0);
        serve_one("s4b", w);
        check("s4_no_wait", 32'(w), 32'd0);

        // 5: reset while RUN with cnt=7; the request is dropped.
        set_req(1, 8'd100);
        #1;
        check("s5_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        repeat (7) tick();
        check("s5_ext_before", 32'(ext_radicand), 32'd100);
        check("s5_state_run",  32'(fsm_state),    32'd1);
        rst_n = 1'b0;
        #1;
        check("s5_ext_rst",   32'(ext_radicand), 32'd0);
        check("s5_state_rst", 32'(fsm_state),    32'd0);
        check("s5_ready_rst", 32'(req_ready),    32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("s5_no_rsp", 32'(seen), 32'd0);
        req_valid = 4'hF;
        #1;
        check("s5_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = '0;
        #1;
        set_req(3, 8'd81);
        push_exp(3, 9, 0);
        #1;
        serve_one("s5", w);

        // 6: boundaries: maximum radicand and zero.
        set_req(1, 8'd255);
        push_exp(1, 15, 30);
        #1;
        serve_one("s6_max", w);
        set_req(2, 8'd0);
        push_exp(2, 0, 0);
        #1;
        serve_one("s6_zero", w);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
- Shares one square_extractor among NREQ requesters.
- Accepts a 2*WIDTH-bit radicand from one requester at a time, chosen by round-robin arbitration.
- Drives the radicand into the extractor and holds it stable for LATENCY cycles, then samples the root and remainder.
- Returns the result on a valid/ready response channel tagged with the requester ID.
- Sits between requesting datapath blocks and the single square_extractor instance at the integration level.

Parameters:
- WIDTH, 4, root width; radicand width is 2*WIDTH.
- NREQ, 4, number of requesters, minimum 2.
- LATENCY, 16, cycles the radicand is held before results are sampled; must be at least the extractor latency (4*WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_radicand  in  NREQ*2*WIDTH  packed radicands; requester i uses bits [i*2*WIDTH +: 2*WIDTH].
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NREQ)  index of the requester being answered.
- rsp_root  out  WIDTH  floor(sqrt(radicand)).
- rsp_rem  out  WIDTH+1  radicand - root^2.
- ext_radicand  out  2*WIDTH  to extractor radicand.
- ext_dout  in  WIDTH  from extractor dout.
- ext_remainder  in  WIDTH+1  from extractor remainder.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, rr pointer 0, cnt 0, ext_radicand 0, rsp_valid 0, rsp_id 0, rsp_root 0, rsp_rem 0. req_ready is 0 while in reset.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Grant g is the first asserted req_valid searching from the pointer upward, with wrap-around.
  - req_ready[g] = 1, combinational from state and req_valid; all other req_ready = 0.
  - Accept happens at the edge where req_valid[g] and req_ready[g] are both 1.
  - On accept: ext_radicand <= req_radicand[g]; rsp_id <= g; pointer <= (g+1) mod NREQ; cnt <= 0; go to RUN.
  - With no valid requests: stay in IDLE, all req_ready = 0.
- RUN:
  - ext_radicand is held constant and cnt increments each cycle.
  - When cnt == LATENCY-1: at the next edge, rsp_root <= ext_dout, rsp_rem <= ext_remainder, rsp_valid <= 1, go to RESP.
  - rsp_valid therefore rises exactly LATENCY cycles after the accept edge.
  - req_ready = 0 throughout.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - A new grant is possible no earlier than the cycle after the response handshake.
  - req_ready = 0.
- Requester rule: a requester holds req_valid and its radicand stable until accepted. Deasserting before acceptance simply removes it from arbitration; this is not an error.
- Simultaneous requests: only one grant per cycle; the pointer guarantees no starvation, with a worst-case wait of NREQ-1 services.
- ext_radicand keeps its last value in IDLE and RESP.
- Reset mid-operation: the in-flight request is dropped with no response, and all registers return to reset values immediately (asynchronous).
- Width rules:
  - rsp_root is exact for radicands 0..2^(2*WIDTH)-1.
  - rsp_rem can reach 2*root, so it is WIDTH+1 bits.
  - No truncation anywhere.

Decomposition:
- Package sqrt_share_pkg holds:
  - state enum (IDLE, RUN, RESP);
  - function clog2-based ID width;
  - default LATENCY constant (4*WIDTH).
- Sub-module rr_arbiter(NREQ): inputs req vector, pointer, enable; outputs one-hot grant and encoded index. It is combinational; the pointer register lives in the parent.
- square_extractor is not instantiated inside; the integration level connects the ext_* ports.

Test Plan:
All scenarios use WIDTH=4, NREQ=4, LATENCY=16, with a square_extractor model on the ext_* ports.
1. Single request from requester 2, radicand 200 -> req_ready[2] for 1 cycle; rsp_valid 16 cycles after accept; rsp_id 2, root 14, rem 4.
2. All four valid after reset with radicands 0, 1, 255, 144; rsp_ready=1 -> service order 0,1,2,3; results (0,0), (1,0), (15,30), (12,0).
3. Round-robin: serve requester 1, then assert 0 and 3 together -> 3 is granted before 0; pointer wraps.
4. Backpressure: rsp_ready=0 for 10 cycles in RESP while requester 0 is valid -> rsp_* stable, req_ready stays 0; requester 0 is accepted the cycle after rsp_ready=1.
5. Reset asserted at RUN cnt=7 -> rsp_valid never rises; ext_radicand 0, pointer 0. After release, request 3 with radicand 81 returns root 9, rem 0.
6. Boundary: radicand 255 -> rem 30 (needs bit WIDTH); radicand 0 -> root 0, rem 0; exactly LATENCY cycles counted.
